ninjin_mem_arb: RTL
===================

NINJIN_MEM_ARB -- requirements
Module: ninjin_mem_arb

Interface
REQ-001 SHALL have parameter CH, default 2 (renkon + gobou), number of requester channels, 2..8.
REQ-002 SHALL have parameter PORT, default 32, memory data width in bits.
REQ-003 SHALL have parameter AWIDTH, default 12, word address width.
REQ-004 SHALL have parameter MAXBURST, default 16, maximum words per burst; LENW = clog2(MAXBURST+1).
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req  in  CH  per-channel burst request.
REQ-008 req_we  in  CH  1 = write burst, 0 = read burst.
REQ-009 req_addr  in  CH*AWIDTH  burst start word address.
REQ-010 req_len  in  CH*LENW  burst length in words.
REQ-011 wdata  in  CH*PORT  per-channel write data.
REQ-012 gnt  out  CH  one-hot; high for every cycle of the granted burst.
REQ-013 wr_ready  out  CH  write beat consumed this cycle.
REQ-014 rdata  out  PORT  read return data; rvalid  out  CH  one-hot return strobe.
REQ-015 mem_en, mem_we  out  1 each; mem_addr  out  AWIDTH; mem_wdata  out  PORT; mem_rdata  in  PORT (1-cycle read latency).
REQ-016 busy  out  1  high while not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE and BURST.
REQ-018 In IDLE with any req high, SHALL select a channel round-robin, starting from the channel after the last granted, latch its we/addr/len, and enter BURST next cycle.
REQ-019 req SHALL be sampled only in IDLE; changes during BURST SHALL be ignored.
REQ-020 req_len of 0 SHALL be treated as 1; values above MAXBURST SHALL be clamped to MAXBURST.
REQ-021 In BURST, beat i (0..len-1) SHALL drive mem_en=1, mem_addr=start+i modulo 2^AWIDTH, mem_we=latched we.
REQ-022 For write bursts, mem_wdata SHALL equal the granted channel's wdata combinationally and wr_ready of that channel SHALL be high each beat.
REQ-023 For read bursts, rvalid of the granted channel SHALL pulse exactly one cycle after each read beat, with rdata = mem_rdata.
REQ-024 After the last beat SHALL return to IDLE; one idle cycle separates consecutive bursts.
REQ-025 The last read return SHALL occur in the IDLE cycle following BURST and SHALL NOT be suppressed.
REQ-026 Outside BURST, mem_en, mem_we, gnt and wr_ready SHALL be 0.

Reset
REQ-027 On rst: state=IDLE; gnt, wr_ready, rvalid, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, rdata = 0; round-robin pointer = channel 0 highest priority.
REQ-028 rst during BURST SHALL abort the burst immediately; no further memory access or rvalid.

Configuration
REQ-029 Macro NINJIN_ARB_STATS_EN SHALL, when defined, add output stat_grants (CH*32 bits): per-channel saturating count of completed bursts, cleared by rst.
REQ-030 Without NINJIN_ARB_STATS_EN, stat_grants and its counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 FSM state enum and the LENW derivation SHALL live in the shared ninjin package alongside PORT.
REQ-032 Round-robin selection SHALL be a sub-module ninjin_rr_arb (request vector, last-grant pointer in; one-hot grant out, combinational).

Verification
REQ-033 Single read: ch0 req, addr=0x010, len=4 -> gnt[0] 4 cycles, mem_addr 0x010..0x013, rvalid[0] 4 pulses one cycle delayed.
REQ-034 Contention: ch0 and ch1 req together after reset, held -> grants alternate ch0, ch1, ch0 with one idle cycle between.
REQ-035 Wrap: write addr=0xFFE, len=4 -> mem_addr 0xFFE, 0xFFF, 0x000, 0x001; wr_ready[ch] high 4 cycles.
REQ-036 Length edge: len=0 -> single beat; len=31 with MAXBURST=16 -> exactly 16 beats.
REQ-037 Reset mid-burst: rst asserted at beat 2 of len=8 read -> mem_en, gnt, rvalid 0 immediately; next grant goes to ch0.
REQ-038 With NINJIN_ARB_STATS_EN: 3 ch1 bursts -> stat_grants ch1 field = 3, ch0 field = 0.

Source files
------------

// File: rtl/ninjin_pkg.sv
// Shared types and constants for the ninjin memory arbiter.
// Holds the FSM state encoding, the default port width and the burst-length width helper.
package ninjin_pkg;

   localparam int PORT_W = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // Bits needed to carry a length value of 0..maxburst.
   function automatic int calc_lenw(input int maxburst);
      return $clog2(maxburst + 1);
   endfunction

endpackage

// File: rtl/ninjin_rr_arb.sv
// Combinational round-robin picker: the first requester after the last-granted
// channel wins; the result is one-hot.
module ninjin_rr_arb
   import ninjin_pkg::*;
#(
   parameter  int CH = 2,
   localparam int PW = $clog2(CH)
) (
   input  logic [CH-1:0] req,
   input  logic [PW-1:0] last,
   output logic [CH-1:0] gnt
);

   logic [PW-1:0] idx;

   // Walk from farthest to nearest so the nearest requester overwrites the rest.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = CH; i >= 1; i--) begin
         idx = PW'((int'(last) + i) % CH);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ninjin_mem_arb.sv
// Multi-channel burst arbiter in front of a single-port memory with 1-cycle read latency.
// Optional per-channel completed-burst counters are enabled by defining NINJIN_ARB_STATS_EN.
module ninjin_mem_arb
   import ninjin_pkg::*;
#(
   parameter  int CH       = 2,
   parameter  int PORT     = PORT_W,
   parameter  int AWIDTH   = 12,
   parameter  int MAXBURST = 16,
   localparam int LENW     = calc_lenw(MAXBURST),
   localparam int PW       = $clog2(CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CH-1:0]        req,
   input  logic [CH-1:0]        req_we,
   input  logic [CH*AWIDTH-1:0] req_addr,
   input  logic [CH*LENW-1:0]   req_len,
   input  logic [CH*PORT-1:0]   wdata,
   output logic [CH-1:0]        gnt,
   output logic [CH-1:0]        wr_ready,
   output logic [PORT-1:0]      rdata,
   output logic [CH-1:0]        rvalid,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [AWIDTH-1:0]    mem_addr,
   output logic [PORT-1:0]      mem_wdata,
   input  logic [PORT-1:0]      mem_rdata,
   output logic                 busy
`ifdef NINJIN_ARB_STATS_EN
   ,
   output logic [CH*32-1:0]     stat_grants
`endif
);

   state_t            state, state_nxt;
   logic [CH-1:0]     arb_gnt, ch_q, rv_q;
   logic [PW-1:0]     last_q, sel_idx;
   logic              we_q, sel_we, in_burst, last_beat;
   logic [AWIDTH-1:0] addr_q, sel_addr;
   logic [LENW-1:0]   rem_q, sel_len;

   function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] l);
      if (l == '0) return LENW'(1);
      if (l > LENW'(MAXBURST)) return LENW'(MAXBURST);
      return l;
   endfunction

   ninjin_rr_arb #(.CH(CH)) u_rr (
      .req  (req),
      .last (last_q),
      .gnt  (arb_gnt)
   );

   assign in_burst  = (state == BURST);
   assign last_beat = (rem_q == LENW'(1));

   always_comb begin
      sel_idx  = '0;
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_len  = '0;
      for (int c = 0; c < CH; c++) begin
         if (arb_gnt[c]) begin
            sel_idx  = PW'(c);
            sel_we   = req_we[c];
            sel_addr = req_addr[c*AWIDTH +: AWIDTH];
            sel_len  = clamp_len(req_len[c*LENW +: LENW]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = in_burst;
      mem_en    = in_burst;
      mem_we    = in_burst & we_q;
      mem_addr  = in_burst ? addr_q : '0;
      gnt       = in_burst ? ch_q : '0;
      wr_ready  = (in_burst && we_q) ? ch_q : '0;
      mem_wdata = '0;
      rvalid    = rv_q;
      rdata     = (|rv_q) ? mem_rdata : '0;
      for (int c = 0; c < CH; c++) begin
         if (in_burst && we_q && ch_q[c]) mem_wdata = wdata[c*PORT +: PORT];
      end
      case (state)
         IDLE:    if (|req) state_nxt = BURST;
         BURST:   if (last_beat) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Burst bookkeeping; read strobe trails each read beat by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_q   <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         rem_q  <= '0;
         last_q <= PW'(CH - 1);
         rv_q   <= '0;
      end else begin
         rv_q <= (in_burst && !we_q) ? ch_q : '0;
         if (state == IDLE && (|req)) begin
            ch_q   <= arb_gnt;
            we_q   <= sel_we;
            addr_q <= sel_addr;
            rem_q  <= sel_len;
            last_q <= sel_idx;
         end else if (in_burst) begin
            addr_q <= addr_q + AWIDTH'(1);
            rem_q  <= rem_q - LENW'(1);
         end
      end
   end

`ifdef NINJIN_ARB_STATS_EN
   logic [31:0] stat_q [CH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CH; c++) stat_q[c] <= '0;
      end else if (in_burst && last_beat) begin
         for (int c = 0; c < CH; c++) begin
            if (ch_q[c] && stat_q[c] != '1) stat_q[c] <= stat_q[c] + 32'd1;
         end
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_stat
      assign stat_grants[g*32 +: 32] = stat_q[g];
   end
`endif

endmodule
